// File: rtl/switch_debouncer_if.sv
// Signal bundle between a raw switch source and the debouncer.
// The master drives the raw pin; the slave returns the cleaned level and busy flag.
interface switch_debouncer_if;
   logic sw;
   logic db;
   logic busy;

   modport master (output sw, input db, input busy);
   modport slave  (input sw, output db, output busy);
endinterface

// File: rtl/switch_debouncer.sv
// Debounces a raw switch input: two-flop synchroniser, free-running sample tick,
// and a Moore FSM that accepts a new level only after it holds for STABLE_TICKS ticks.
module switch_debouncer #(
   parameter int TICK_W       = 19,
   parameter int STABLE_TICKS = 3
) (
   input  logic              clk,
   input  logic              reset,
   switch_debouncer_if.slave bus
);

   localparam int CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_TICKS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Encodings chosen so bit 1 is the debounced level and bit 0 the busy flag
   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT1 = 2'b01,
      ONE   = 2'b10,
      WAIT0 = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       sync_q;
   logic [TICK_W-1:0] tickCnt_q;
   logic [CNT_W-1:0] qCnt_q, qCnt_d;
   logic             swS;
   logic             mTick;

   assign swS   = sync_q[1];
   assign mTick = &tickCnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         tickCnt_q <= '0;
         qCnt_q    <= '0;
         state_q   <= ZERO;
      end else begin
         sync_q    <= {sync_q[0], bus.sw};
         tickCnt_q <= tickCnt_q + 1'b1;
         qCnt_q    <= qCnt_d;
         state_q   <= state_d;
      end
   end

   // A level reversal during qualification always wins over a coincident tick
   always_comb begin
      state_d = state_q;
      qCnt_d  = qCnt_q;
      case (state_q)
         ZERO: begin
            if (swS) begin
               state_d = WAIT1;
               qCnt_d  = CNT_LOAD;
            end
         end
         WAIT1: begin
            if (!swS) begin
               state_d = ZERO;
            end else if (mTick) begin
               if (qCnt_q == CNT_ONE) begin
                  state_d = ONE;
               end else begin
                  qCnt_d = qCnt_q - 1'b1;
               end
            end
         end
         ONE: begin
            if (!swS) begin
               state_d = WAIT0;
               qCnt_d  = CNT_LOAD;
            end
         end
         WAIT0: begin
            if (swS) begin
               state_d = ONE;
            end else if (mTick) begin
               if (qCnt_q == CNT_ONE) begin
                  state_d = ZERO;
               end else begin
                  qCnt_d = qCnt_q - 1'b1;
               end
            end
         end
         default: state_d = ZERO;
      endcase
   end

   assign bus.db   = (state_q == ONE)   || (state_q == WAIT0);
   assign bus.busy = (state_q == WAIT1) || (state_q == WAIT0);

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus random switch
// activity, every cycle compared against a tick-counting reference model.
module tb_switch_debouncer;

   localparam int TICK_W       = 3;
   localparam int STABLE_TICKS = 3;
   localparam int TICK_PERIOD  = 1 << TICK_W;

   logic clk = 1'b0;
   logic reset;

   switch_debouncer_if bus ();

   switch_debouncer #(
      .TICK_W       (TICK_W),
      .STABLE_TICKS (STABLE_TICKS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int vectorCount = 0;
   int missCount   = 0;
   bit checkEn     = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: a pending change is accepted on the STABLE_TICKS-th tick
   // seen after the synchronised input first disagrees with the accepted level.
   logic [1:0] syncM  = '0;
   int         tickM  = 0;
   logic       dbM    = 1'b0;
   logic       pendM  = 1'b0;
   int         ticksM = 0;

   always @(posedge clk) begin
      logic swSeen;
      logic nDb, nPend;
      int   nTicks;
      if (reset) begin
         syncM  <= '0;
         tickM  <= 0;
         dbM    <= 1'b0;
         pendM  <= 1'b0;
         ticksM <= 0;
      end else begin
         swSeen = syncM[1];
         nDb    = dbM;
         nPend  = pendM;
         nTicks = ticksM;
         if (!pendM) begin
            if (swSeen != dbM) begin
               nPend  = 1'b1;
               nTicks = 0;
            end
         end else if (swSeen == dbM) begin
            nPend = 1'b0;
         end else if (tickM == TICK_PERIOD - 1) begin
            nTicks = ticksM + 1;
            if (nTicks == STABLE_TICKS) begin
               nDb   = ~dbM;
               nPend = 1'b0;
            end
         end
         syncM  <= {syncM[0], bus.sw};
         tickM  <= (tickM + 1) % TICK_PERIOD;
         dbM    <= nDb;
         pendM  <= nPend;
         ticksM <= nTicks;
      end
   end

   // Per-cycle comparison and db edge counting, away from the active edge
   int   riseCount = 0;
   int   fallCount = 0;
   logic prevDb    = 1'b0;

   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("db", {31'b0, bus.db}, {31'b0, dbM});
         checkOutput("busy", {31'b0, bus.busy}, {31'b0, pendM});
         if (prevDb === 1'b0 && bus.db === 1'b1) riseCount <= riseCount + 1;
         if (prevDb === 1'b1 && bus.db === 1'b0) fallCount <= fallCount + 1;
         prevDb <= bus.db;
      end
   end

   task automatic applyStimulus(input logic swVal, input logic rstVal, input int n);
      repeat (n) begin
         @(negedge clk);
         bus.sw = swVal;
         reset  = rstVal;
      end
   endtask

   // Counts negedges until db reaches the wanted level, giving up after maxCyc
   task automatic waitDb(input logic level, input int maxCyc, output int n);
      n = 0;
      while (bus.db !== level && n < maxCyc) begin
         @(negedge clk);
         n++;
      end
   endtask

   int lat;
   int riseBase, fallBase;

   initial begin
      bus.sw  = 1'b1;
      reset   = 1'b1;
      checkEn = 1'b1;

      // Reset dominates a held-high switch
      applyStimulus(1'b1, 1'b1, 2);
      checkOutput("reset_db", {31'b0, bus.db}, 32'd0);
      checkOutput("reset_busy", {31'b0, bus.busy}, 32'd0);

      // Release with switch still high: a full window must elapse
      applyStimulus(1'b1, 1'b0, 1);
      waitDb(1'b1, 40, lat);
      checkOutput("rst_release_window", {31'b0, (lat >= 19 && lat <= 26)}, 32'd1);

      // Clean release, then a clean press
      applyStimulus(1'b0, 1'b0, 1);
      waitDb(1'b0, 40, lat);
      checkOutput("clean_release_window", {31'b0, (lat >= 19 && lat <= 27)}, 32'd1);
      applyStimulus(1'b0, 1'b0, 10);
      riseBase = riseCount;
      applyStimulus(1'b1, 1'b0, 1);
      waitDb(1'b1, 40, lat);
      checkOutput("clean_press_window", {31'b0, (lat >= 19 && lat <= 27)}, 32'd1);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("clean_press_edges", riseCount - riseBase, 32'd1);

      // Bouncing release ending low: exactly one falling edge
      fallBase = fallCount;
      for (int i = 0; i < 12; i++) applyStimulus(i[0] ? 1'b1 : 1'b0, 1'b0, 3);
      checkOutput("bounce_release_hold", {31'b0, bus.db}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1);
      waitDb(1'b0, 40, lat);
      checkOutput("bounce_release_window", {31'b0, (lat >= 19 && lat <= 27)}, 32'd1);
      applyStimulus(1'b0, 1'b0, 20);
      checkOutput("bounce_release_edges", fallCount - fallBase, 32'd1);

      // Bouncing press ending high: exactly one rising edge
      riseBase = riseCount;
      for (int i = 0; i < 12; i++) applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 3);
      checkOutput("bounce_press_hold", {31'b0, bus.db}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1);
      waitDb(1'b1, 40, lat);
      checkOutput("bounce_press_window", {31'b0, (lat >= 19 && lat <= 27)}, 32'd1);
      applyStimulus(1'b1, 1'b0, 20);
      checkOutput("bounce_press_edges", riseCount - riseBase, 32'd1);

      // Short glitches from a settled low level are rejected
      applyStimulus(1'b0, 1'b0, 1);
      waitDb(1'b0, 40, lat);
      applyStimulus(1'b0, 1'b0, 10);
      riseBase = riseCount;
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 4);
      checkOutput("glitch1_busy", {31'b0, bus.busy}, 32'd0);
      applyStimulus(1'b1, 1'b0, 7);
      applyStimulus(1'b0, 1'b0, 4);
      checkOutput("glitch7_busy", {31'b0, bus.busy}, 32'd0);
      applyStimulus(1'b0, 1'b0, 30);
      checkOutput("glitch_edges", riseCount - riseBase, 32'd0);

      // Reset lands on the edge that would have completed qualification
      applyStimulus(1'b1, 1'b1, 2);
      applyStimulus(1'b1, 1'b0, 23);
      checkOutput("pre_abort_busy", {31'b0, bus.busy}, 32'd1);
      applyStimulus(1'b1, 1'b1, 1);
      @(negedge clk);
      checkOutput("abort_db", {31'b0, bus.db}, 32'd0);
      checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1);
      waitDb(1'b1, 40, lat);
      checkOutput("abort_rewindow", {31'b0, (lat >= 19 && lat <= 26)}, 32'd1);

      // Random switch activity with occasional resets
      for (int seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 15) == 0) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 2));
         end
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom_range(1, 35));
      end
      applyStimulus(bus.sw, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
